// File: rtl/regdec_pkg.sv
// Shared defaults and helpers for the register-file write decoder.
// Optional feature macro used by the decoder: REGDEC_ZERO_REG_EN (hardwired-zero register 0).
package regdec_pkg;

    localparam int ADDR_W_DEF = 4;
    localparam int CNT_W_DEF  = 8;
    localparam int DEPTH_DEF  = 1 << ADDR_W_DEF;

    function automatic int psel_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic logic [DEPTH_DEF-1:0] onehot(input logic [ADDR_W_DEF-1:0] addr);
        logic [DEPTH_DEF-1:0] v;
        v       = {DEPTH_DEF{1'b0}};
        v[addr] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/regdec_port_onehot.sv
// Combinational per-port address to one-hot converter; all zero when the port is idle.
module regdec_port_onehot
    import regdec_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic                     valid,
    input  logic [ADDR_W-1:0]        addr,
    output logic [(1 << ADDR_W)-1:0] oh
);

    localparam int DEPTH = 1 << ADDR_W;

    generate
        if (ADDR_W == ADDR_W_DEF) begin : g_pkg
            assign oh = valid ? onehot(addr) : {DEPTH{1'b0}};
        end else begin : g_generic
            // Non-default widths compare against every register index directly.
            always_comb begin
                oh = {DEPTH{1'b0}};
                for (int r = 0; r < DEPTH; r++) begin
                    oh[r] = valid & (addr == ADDR_W'(r));
                end
            end
        end
    endgenerate

endmodule

// File: rtl/regfile_wr_decoder.sv
// Registered multi-port write-address decoder with lowest-port-wins conflict resolution.
// Define REGDEC_ZERO_REG_EN to make register 0 a hardwired zero (writes to it are discarded).
module regfile_wr_decoder
    import regdec_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int NUM_PORTS = 2,
    parameter int CNT_W     = CNT_W_DEF
) (
    input  logic                                              clk,
    input  logic                                              rst_n,
    input  logic [NUM_PORTS-1:0]                              wr_valid_i,
    input  logic [NUM_PORTS*ADDR_W-1:0]                       wr_addr_i,
    input  logic                                              stall_i,
    input  logic                                              cnt_clr_i,
    output logic [(1 << ADDR_W)-1:0]                          we_onehot_o,
    output logic [(1 << ADDR_W)*psel_w(NUM_PORTS)-1:0]        port_sel_o,
    output logic                                              out_valid_o,
    output logic                                              conflict_o,
    output logic [CNT_W-1:0]                                  conflict_cnt_o
);

    localparam int DEPTH  = 1 << ADDR_W;
    localparam int PSEL_W = psel_w(NUM_PORTS);

`ifdef REGDEC_ZERO_REG_EN
    localparam logic ZERO_REG = 1'b1;
`else
    localparam logic ZERO_REG = 1'b0;
`endif

    logic [ADDR_W-1:0]       addr_s    [NUM_PORTS];
    logic [NUM_PORTS-1:0]    valid_s;
    logic [DEPTH-1:0]        port_oh_s [NUM_PORTS];
    logic [DEPTH-1:0]        we_s;
    logic [DEPTH*PSEL_W-1:0] psel_s;
    logic                    conflict_s;

    logic [DEPTH-1:0]        we_r;
    logic [DEPTH*PSEL_W-1:0] psel_r;
    logic                    out_valid_r;
    logic                    conflict_r;
    logic [CNT_W-1:0]        cnt_r;

    // Per-port address slicing and zero-register masking ahead of decode.
    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            addr_s[p]  = wr_addr_i[p*ADDR_W +: ADDR_W];
            valid_s[p] = wr_valid_i[p] & ~(ZERO_REG & (addr_s[p] == {ADDR_W{1'b0}}));
        end
    end

    generate
        for (genvar gp = 0; gp < NUM_PORTS; gp++) begin : g_port
            regdec_port_onehot #(.ADDR_W(ADDR_W)) u_oh (
                .valid (valid_s[gp]),
                .addr  (addr_s[gp]),
                .oh    (port_oh_s[gp])
            );
        end
    endgenerate

    // Merge per-port one-hots; walking ports high to low leaves the lowest hitting port selected.
    always_comb begin
        we_s   = {DEPTH{1'b0}};
        psel_s = {(DEPTH*PSEL_W){1'b0}};
        for (int r = 0; r < DEPTH; r++) begin
            for (int p = NUM_PORTS - 1; p >= 0; p--) begin
                we_s[r] = we_s[r] | port_oh_s[p][r];
                psel_s[r*PSEL_W +: PSEL_W] = port_oh_s[p][r] ? PSEL_W'(p)
                                                            : psel_s[r*PSEL_W +: PSEL_W];
            end
        end
    end

    // Any pair of surviving ports sharing a full-width address is a conflict.
    always_comb begin
        conflict_s = 1'b0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            for (int q = p + 1; q < NUM_PORTS; q++) begin
                conflict_s = conflict_s | (valid_s[p] & valid_s[q] & (addr_s[p] == addr_s[q]));
            end
        end
    end

    // Output stage; a stall freezes every decode output and drops the sampled request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_r        <= {DEPTH{1'b0}};
            psel_r      <= {(DEPTH*PSEL_W){1'b0}};
            out_valid_r <= 1'b0;
            conflict_r  <= 1'b0;
        end else if (!stall_i) begin
            we_r        <= we_s;
            psel_r      <= psel_s;
            out_valid_r <= |we_s;
            conflict_r  <= conflict_s;
        end
    end

    // Saturating conflict counter; clear wins over an increment and works during stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (cnt_clr_i) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (!stall_i && conflict_s && (cnt_r != {CNT_W{1'b1}})) begin
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign we_onehot_o    = we_r;
    assign port_sel_o     = psel_r;
    assign out_valid_o    = out_valid_r;
    assign conflict_o     = conflict_r;
    assign conflict_cnt_o = cnt_r;

endmodule
